// File: rtl/shared_eval_pkg.sv
// Shared types, operand bit positions and the golden evaluation function
// for the time-multiplexed evaluation scheduler.
package shared_eval_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int A0 = 0;
    localparam int A1 = 1;
    localparam int A2 = 2;
    localparam int A3 = 3;

    function automatic logic fn_eval_f(input logic [3:0] a);
        return a[A0] & ((a[A1] & a[A3]) | (a[A1] ^ a[A2]));
    endfunction

endpackage

// File: rtl/shared_eval_sched_fn_eval.sv
// Shared 4-input evaluation cone; fed only from the isolation register so
// it toggles only when a new operand set is accepted.
module fn_eval
    import shared_eval_pkg::*;
(
    input  logic [3:0] op_i,
    output logic       y_o
);

    assign y_o = op_i[A0] & ((op_i[A1] & op_i[A3]) | (op_i[A1] ^ op_i[A2]));

endmodule

// File: rtl/shared_eval_sched.sv
// Round-robin scheduler sharing one fn_eval cone among NREQ requesters,
// with operand isolation and a single buffered response channel.
module shared_eval_sched
    import shared_eval_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_data,
    input  logic              resp_ready,
    output logic [CW-1:0]     eval_cnt
);

    state_t         state_q;
    logic [IDW-1:0] last_q;
    logic [3:0]     op_q;
    logic [IDW-1:0] id_q;
    logic           resp_valid_q;
    logic [IDW-1:0] resp_id_q;
    logic           resp_data_q;
    logic [CW-1:0]  cnt_q;

    logic [NREQ-1:0] rot_req;
    logic [IDW-1:0]  rot_src;
    logic [IDW-1:0]  rot_idx;
    logic            grant_any;
    logic [IDW-1:0]  grant_idx_d;
    logic [NREQ-1:0] grant_oh;
    logic            can_accept;
    logic            handshake;
    logic            y;

    // Rotate so that bit 0 is the requester just after the last winner.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rot_req = '0;
        rot_src = '0;
        for (int j = 0; j < NREQ; j++) begin
            rot_src    = IDW'((int'(last_q) + 1 + j) % NREQ);
            rot_req[j] = req_valid[rot_src];
        end
    end

    always_comb begin
        rot_idx   = '0;
        grant_any = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot_req[j]) begin
                rot_idx   = IDW'(j);
                grant_any = 1'b1;
            end
        end
    end

    assign grant_idx_d = IDW'((int'(rot_idx) + int'(last_q) + 1) % NREQ);

    always_comb begin
        grant_oh = '0;
        if (grant_any) grant_oh[grant_idx_d] = 1'b1;
    end

    assign can_accept = (state_q == IDLE) || (state_q == RESP && resp_ready);
    assign req_ready  = grant_oh & {NREQ{can_accept}};
    assign handshake  = |req_ready;

    fn_eval u_fn_eval (
        .op_i (op_q),
        .y_o  (y)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= IDW'(NREQ - 1);
            op_q         <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) state_q <= EVAL;
                end
                EVAL: begin
                    resp_data_q  <= y;
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= handshake ? EVAL : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Operand isolation: op_q changes only on an accepted request.
            if (handshake) begin
                op_q   <= req_data[{grant_idx_d, 2'b00} +: 4];
                id_q   <= grant_idx_d;
                last_q <= grant_idx_d;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign eval_cnt   = cnt_q;

endmodule

// File: tb/tb_shared_eval_sched.sv
// Directed self-checking bench for shared_eval_sched (NREQ=4), with a second
// CW=4 instance on the same stimulus for counter saturation.
module tb_shared_eval_sched;
    import shared_eval_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CW   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic              resp_data;
    logic              resp_ready;
    logic [CW-1:0]     eval_cnt;

    logic [NREQ-1:0]   req_ready_s;
    logic              resp_valid_s;
    logic [IDW-1:0]    resp_id_s;
    logic              resp_data_s;
    logic [3:0]        eval_cnt_s;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    shared_eval_sched #(.NREQ(NREQ), .IDW(IDW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .eval_cnt   (eval_cnt)
    );

    shared_eval_sched #(.NREQ(NREQ), .IDW(IDW), .CW(4)) sat_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready_s),
        .resp_valid (resp_valid_s),
        .resp_id    (resp_id_s),
        .resp_data  (resp_data_s),
        .resp_ready (resp_ready),
        .eval_cnt   (eval_cnt_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    // One isolated request from requester idx; resp_ready held high.
    task automatic do_single(input int idx, input logic [3:0] d, input logic exp_y);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << idx;
        req_valid = oh;
        req_data = '0;
        req_data[4*idx +: 4] = d;
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== oh) begin errors++; $display("FAIL single_ready: got %b want %b", req_ready, oh); end
        tick();
        req_valid = '0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_eval_valid: got %b want 0", resp_valid); end
        tick();
        exp_cnt++;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", resp_valid); end
        checks++; if (resp_id !== IDW'(idx)) begin errors++; $display("FAIL single_id: got %0d want %0d", resp_id, idx); end
        checks++; if (resp_data !== exp_y) begin errors++; $display("FAIL single_data d=%b: got %b want %b", d, resp_data, exp_y); end
        checks++; if (eval_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL single_cnt: got %0d want %0d", eval_cnt, exp_cnt); end
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
        checks++; if (resp_id !== '0) begin errors++; $display("FAIL rst_id: got %0d want 0", resp_id); end
        checks++; if (resp_data !== 1'b0) begin errors++; $display("FAIL rst_data: got %b want 0", resp_data); end
        checks++; if (eval_cnt !== '0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", eval_cnt); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        checks++; if (dut.op_q !== 4'b0) begin errors++; $display("FAIL rst_op: got %b want 0", dut.op_q); end
    endtask

    task automatic test_single();
        do_single(2, 4'b0011, 1'b1);
    endtask

    task automatic test_function();
        do_single(0, 4'b1010, 1'b0);
        do_single(0, 4'b1111, 1'b1);
        do_single(0, 4'b0111, 1'b0);
        do_single(0, 4'b0101, 1'b1);
        for (int c = 0; c < 16; c++) do_single(0, 4'(c), fn_eval_f(4'(c)));
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] oh;
        logic [3:0] rr_y;
        int e;
        apply_reset();
        // r0=1010->0, r1=0011->1, r2=1111->1, r3=0000->0
        rr_y = 4'b0110;
        req_data = 16'h0F3A;
        req_valid = 4'hF;
        resp_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            e = i % NREQ;
            oh = NREQ'(1) << e;
            checks++; if (req_ready !== oh) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, oh); end
            tick();
            checks++; if (req_ready !== '0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rr_eval%0d: ready %b valid %b want 0/0", i, req_ready, resp_valid); end
            tick();
            exp_cnt++;
            checks++; if (resp_valid !== 1'b1 || resp_id !== IDW'(e)) begin errors++; $display("FAIL rr_resp%0d: valid %b id %0d want 1/%0d", i, resp_valid, resp_id, e); end
            checks++; if (resp_data !== rr_y[e]) begin errors++; $display("FAIL rr_data%0d: got %b want %b", i, resp_data, rr_y[e]); end
        end
        checks++; if (eval_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL rr_cnt: got %0d want %0d", eval_cnt, exp_cnt); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        req_data = '0;
        req_data[7:4]  = 4'b0101;
        req_data[11:8] = 4'b0111;
        req_valid = 4'b0110;
        resp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0100;
        tick();
        exp_cnt++;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 1'b1 || req_ready !== '0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid %b id %0d data %b ready %b want 1/1/1/0000", i, resp_valid, resp_id, resp_data, req_ready);
            end
            tick();
        end
        checks++; if (eval_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL bp_cnt_hold: got %0d want %0d", eval_cnt, exp_cnt); end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b want 0", resp_valid); end
        tick();
        exp_cnt++;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 1'b0) begin errors++; $display("FAIL bp_resp2: valid %b id %0d data %b want 1/2/0", resp_valid, resp_id, resp_data); end
        tick();
    endtask

    task automatic test_reset_mid_eval();
        req_data = '0;
        req_data[3:0] = 4'b0011;
        req_valid = 4'b0001;
        resp_ready = 1'b1;
        #1;
        tick();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        exp_cnt = 0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", resp_valid); end
        checks++; if (eval_cnt !== '0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", eval_cnt); end
        checks++; if (dut.op_q !== 4'b0) begin errors++; $display("FAIL mid_op: got %b want 0", dut.op_q); end
        rst_n = 1'b1;
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid: got %b want 0", resp_valid); end
        req_data = 16'h0F3A;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_priority: got %b want 0001", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_saturation();
        int exp_s;
        apply_reset();
        for (int n = 1; n <= 20; n++) begin
            do_single(n % NREQ, 4'b1111, 1'b1);
            exp_s = (n > 15) ? 15 : n;
            checks++; if (eval_cnt_s !== 4'(exp_s)) begin errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", n, eval_cnt_s, exp_s); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        resp_ready = 1'b0;
        test_reset();
        test_single();
        test_function();
        test_round_robin();
        test_backpressure();
        test_reset_mid_eval();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_eval_sched.md
# shared_eval_sched

Time-multiplexes one instance of the 4-input power-benchmark evaluation function y = a0 & ((a1 & a3) | (a1 ^ a2)) among NREQ requesters. A round-robin arbiter selects the requester, and an operand-isolation register holds the datapath inputs frozen between evaluations to suppress switching activity. A single buffered response channel returns the result. It sits between the per-requester logic-evaluation front ends and the shared evaluation cone in the power sub-circuit experiments.

## Interface
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), response requester-id width
- CW, 16, width of the saturating evaluation counter
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_data  in  4*NREQ  operands; requester i uses bits [4i+3:4i], bit 4i = a0 ... bit 4i+3 = a3
- req_ready  out  NREQ  one-hot accept; at most one bit high
- resp_valid  out  1  result available
- resp_id  out  IDW  index of the requester the result belongs to
- resp_data  out  1  evaluated y
- resp_ready  in  1  consumer accepts the response
- eval_cnt  out  CW  number of completed evaluations, saturating

## Operation
- FSM states: IDLE, EVAL, RESP.
- can_accept = (state==IDLE) | (state==RESP & resp_ready).
- Arbiter: priority starts at (last_grant+1) mod NREQ and searches upward with wrap.
  - grant is one-hot among the asserted req_valid bits.
  - req_ready = grant & {NREQ{can_accept}}.
  - last_grant updates only on a handshake.
- Handshake on requester i when req_valid[i] & req_ready[i] at a rising edge:
  - op_reg <= req_data slice i.
  - id_reg <= i.
  - state -> EVAL.
- Operand isolation: op_reg loads only on a handshake and otherwise holds its value. The evaluation cone is fed only from op_reg.
- EVAL: at the next edge, resp_data <= f(op_reg), resp_id <= id_reg, resp_valid <= 1, state -> RESP, and eval_cnt increments (saturates at 2^CW-1).
- RESP: outputs hold while resp_ready=0.
  - On resp_ready=1 with a pending grant: back-to-back. resp_valid drops, the new handshake occurs, and state -> EVAL.
  - On resp_ready=1 with no request: state -> IDLE.
- Requesters hold req_valid and req_data stable until handshake. Dropping valid early is a protocol violation, and the block takes no defined action for it.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - state=IDLE, resp_valid=0, resp_id=0, resp_data=0.
  - op_reg=0, id_reg=0, eval_cnt=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
- req_ready is combinational from req_valid, state and resp_ready. No other combinational input-to-output path exists.
- Latency: handshake at edge k; resp_valid=1 after edge k+1.
- Throughput: one result per 2 cycles with resp_ready held high.
- Simultaneous requests: exactly one is granted per handshake. The others wait; no starvation, and the worst-case wait is NREQ grants.
- Reset mid-operation: any in-flight request and response is discarded, with no partial response. eval_cnt clears.
- Reset dominates every other event in the same cycle.

## Structure
- Package shared_eval_pkg holds:
  - the state enum typedef (IDLE, EVAL, RESP);
  - the operand bit-index constants A0..A3;
  - the function fn_eval_f(logic [3:0]) as the golden model, shared with the bench.
- One sub-module, fn_eval: purely combinational 4-in/1-out cone, implementing y = a0 & ((a1 & a3) | (a1 ^ a2)).
- The arbiter is inline: rotate, priority-encode, un-rotate.

## Test plan
- Single request, requester 2, data 4'b0011, resp_ready=1. Required: req_ready[2] in the same cycle; two edges later resp_valid=1, resp_id=2, resp_data=1; eval_cnt=1.
- Function coverage via requester 0, one at a time:
  - 4'b1010 -> 0
  - 4'b1111 -> 1
  - 4'b0111 -> 0
  - 4'b0101 -> 1
  - all 16 codes match fn_eval_f.
- All 4 requesters valid continuously after reset, resp_ready=1. Required grant order 0,1,2,3,0,...; responses every 2 cycles; resp_id follows the same order.
- Backpressure: resp_ready=0 for 5 cycles during RESP. Required: resp_valid, resp_id and resp_data stable; req_ready all 0. On resp_ready=1, the next grant occurs in that cycle.
- Reset mid-EVAL: rst_n=0 for 1 cycle. Required: resp_valid stays 0, eval_cnt=0, op_reg=0. After release, requester 0 wins priority.
- Saturation with CW=4: 20 evaluations. Required: eval_cnt stops at 15.
